// File: rtl/led_panel_pkg.sv
// Shared state encoding and width helper for the LED panel BCM driver.
package led_panel_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        LATCH   = 2'd2,
        DISPLAY = 2'd3
    } state_t;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int width_of(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/led_panel_bcm_timer.sv
// BCM on-time counter: loaded during LATCH, done flags the last DISPLAY cycle.
// Latency: done rises BASE_CYCLES<<plane cycles after the load cycle.
// Backpressure: none; load always restarts the count.
module led_panel_bcm_timer
    import led_panel_pkg::*;
#(
    parameter  int DEPTH       = 4,
    parameter  int BASE_CYCLES = 16,
    localparam int PW          = width_of(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          load,
    input  logic [PW-1:0] plane,
    output logic          done
);

    localparam int MAX_CYC = BASE_CYCLES << (DEPTH - 1);
    localparam int CW      = width_of(MAX_CYC + 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] load_val;

    // Count down from N-1 so that done coincides with the N-th display cycle.
    assign load_val = CW'((BASE_CYCLES << plane) - 1);
    assign done     = (cnt == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/led_panel_bcm.sv
// HUB75-style panel driver: shifts one row per bit plane, latches, then shows it BCM-weighted.
// Latency: panel outputs register the state one cycle behind; frame_start marks the first SHIFT cycle.
// Backpressure: none; en is honoured only at frame boundaries, pixel source must answer combinationally.
module led_panel_bcm
    import led_panel_pkg::*;
#(
    parameter  int COLS        = 32,
    parameter  int ADDR_W      = 2,
    parameter  int DEPTH       = 4,
    parameter  int BASE_CYCLES = 16,
    localparam int CW          = width_of(COLS),
    localparam int PW          = width_of(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic [DEPTH-1:0]  pix_r,
    input  logic [DEPTH-1:0]  pix_g,
    input  logic [DEPTH-1:0]  pix_b,
    output logic [CW-1:0]     pix_col,
    output logic [ADDR_W-1:0] pix_row,
    output logic              red_out,
    output logic              green_out,
    output logic              blue_out,
    output logic              sclk_out,
    output logic              latch_out,
    output logic              blank_out,
    output logic [ADDR_W-1:0] row_out,
    output logic              frame_start
);

    state_t            state_q, state_d;
    logic [CW-1:0]     col_q;
    logic              phase_q;
    logic [ADDR_W-1:0] row_q;
    logic [PW-1:0]     plane_q;

    logic shift_last, last_plane, frame_end, disp_done, timer_load, frame_go;

    assign shift_last = phase_q && (col_q == CW'(COLS - 1));
    assign last_plane = (plane_q == PW'(DEPTH - 1));
    assign frame_end  = last_plane && (&row_q);
    assign timer_load = (state_q == LATCH);

    assign pix_col = col_q;
    assign pix_row = row_q;

    led_panel_bcm_timer #(
        .DEPTH      (DEPTH),
        .BASE_CYCLES(BASE_CYCLES)
    ) u_timer (
        .clk    (clk),
        .reset_n(reset_n),
        .load   (timer_load),
        .plane  (plane_q),
        .done   (disp_done)
    );

    always_comb begin
        state_d  = state_q;
        frame_go = 1'b0;
        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d  = SHIFT;
                    frame_go = 1'b1;
                end
            end
            SHIFT: begin
                if (shift_last) state_d = LATCH;
            end
            LATCH: state_d = DISPLAY;
            DISPLAY: begin
                if (disp_done) begin
                    // en is only consulted once the whole frame has been shown.
                    if (frame_end && !en) begin
                        state_d = IDLE;
                    end else begin
                        state_d  = SHIFT;
                        frame_go = frame_end;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            col_q   <= '0;
            phase_q <= 1'b0;
            row_q   <= '0;
            plane_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    col_q   <= '0;
                    phase_q <= 1'b0;
                    row_q   <= '0;
                    plane_q <= '0;
                end
                SHIFT: begin
                    phase_q <= ~phase_q;
                    if (phase_q) col_q <= shift_last ? '0 : col_q + CW'(1);
                end
                DISPLAY: begin
                    if (disp_done) begin
                        if (last_plane) begin
                            plane_q <= '0;
                            row_q   <= row_q + ADDR_W'(1);
                        end else begin
                            plane_q <= plane_q + PW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            red_out     <= 1'b0;
            green_out   <= 1'b0;
            blue_out    <= 1'b0;
            sclk_out    <= 1'b0;
            latch_out   <= 1'b0;
            blank_out   <= 1'b1;
            row_out     <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= frame_go;
            case (state_q)
                IDLE: begin
                    red_out   <= 1'b0;
                    green_out <= 1'b0;
                    blue_out  <= 1'b0;
                    sclk_out  <= 1'b0;
                    latch_out <= 1'b0;
                    blank_out <= 1'b1;
                end
                SHIFT: begin
                    latch_out <= 1'b0;
                    blank_out <= 1'b1;
                    // Data moves with the falling sclk so it is settled at the rising edge.
                    if (!phase_q) begin
                        sclk_out  <= 1'b0;
                        red_out   <= pix_r[plane_q];
                        green_out <= pix_g[plane_q];
                        blue_out  <= pix_b[plane_q];
                    end else begin
                        sclk_out  <= 1'b1;
                    end
                end
                LATCH: begin
                    sclk_out  <= 1'b0;
                    latch_out <= 1'b1;
                    blank_out <= 1'b1;
                    row_out   <= row_q;
                end
                DISPLAY: begin
                    sclk_out  <= 1'b0;
                    latch_out <= 1'b0;
                    blank_out <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_led_panel_bcm.sv
// Randomized bench: frame-schedule reference model checked cycle by cycle, plus a large-parameter period check.
module tb_led_panel_bcm;

    localparam int COLS   = 4;
    localparam int ADDR_W = 1;
    localparam int DEPTH  = 2;
    localparam int BASE   = 2;
    localparam int ROWS   = 1 << ADDR_W;
    localparam int CW     = (COLS < 2) ? 1 : $clog2(COLS);

    function automatic int frame_cycles(input int cols, input int rows, input int depth, input int base);
        int sum;
        sum = 0;
        for (int p = 0; p < depth; p++) sum += 2 * cols + 1 + (base << p);
        return rows * sum;
    endfunction

    localparam int FRAME    = frame_cycles(COLS, ROWS, DEPTH, BASE);
    localparam int SW_FRAME = frame_cycles(32, 16, 8, 1);

    logic clk;
    logic reset_n, en;
    logic [DEPTH-1:0] pix_r, pix_g, pix_b;
    logic [CW-1:0] pix_col;
    logic [ADDR_W-1:0] pix_row, row_out;
    logic red_out, green_out, blue_out, sclk_out, latch_out, blank_out, frame_start;

    logic pix_mode;
    logic [3*DEPTH-1:0] img [ROWS][COLS];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign pix_r = pix_mode ? img[pix_row][pix_col][3*DEPTH-1 -: DEPTH] : DEPTH'(pix_col);
    assign pix_g = pix_mode ? img[pix_row][pix_col][2*DEPTH-1 -: DEPTH] : DEPTH'(~pix_col);
    assign pix_b = pix_mode ? img[pix_row][pix_col][DEPTH-1 -: DEPTH]   : DEPTH'(pix_row);

    led_panel_bcm #(.COLS(COLS), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_CYCLES(BASE)) dut (
        .clk(clk), .reset_n(reset_n), .en(en),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .pix_col(pix_col), .pix_row(pix_row),
        .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
        .sclk_out(sclk_out), .latch_out(latch_out), .blank_out(blank_out),
        .row_out(row_out), .frame_start(frame_start)
    );

    // Large configuration, only its frame period is observed.
    logic sw_reset_n;
    logic [4:0] sw_pix_col;
    logic [3:0] sw_pix_row, sw_row_out;
    logic [7:0] sw_pix_r, sw_pix_g, sw_pix_b;
    logic sw_red, sw_green, sw_blue, sw_sclk, sw_latch, sw_blank, sw_fs;

    assign sw_pix_r = {3'b000, sw_pix_col};
    assign sw_pix_g = {4'h0, sw_pix_row};
    assign sw_pix_b = 8'hA5;

    led_panel_bcm #(.COLS(32), .ADDR_W(4), .DEPTH(8), .BASE_CYCLES(1)) dut_sweep (
        .clk(clk), .reset_n(sw_reset_n), .en(1'b1),
        .pix_r(sw_pix_r), .pix_g(sw_pix_g), .pix_b(sw_pix_b),
        .pix_col(sw_pix_col), .pix_row(sw_pix_row),
        .red_out(sw_red), .green_out(sw_green), .blue_out(sw_blue),
        .sclk_out(sw_sclk), .latch_out(sw_latch), .blank_out(sw_blank),
        .row_out(sw_row_out), .frame_start(sw_fs)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference pixel value for the current source: {r, g, b}.
    function automatic logic [3*DEPTH-1:0] pix_ref(input int row, input int col);
        int ncol;
        if (pix_mode) return img[row][col];
        ncol = ~col;
        return {DEPTH'(col), DEPTH'(ncol), DEPTH'(row)};
    endfunction

    int   mode = 2;      // 1: inside a frame, 2: idle
    int   pos  = 0;      // state position within the current frame
    int   exp_row = 0;
    int   rises = 0, latches = 0;
    logic cont = 1'b0, exp_fs, en_prev = 1'b0, sclk_prev = 1'b0;

    // Outputs observed now reflect schedule slot s of the frame.
    task automatic check_frame_pos(input int s);
        int rem, row, plane, col, phase, kind, len;
        logic [3*DEPTH-1:0] px;
        logic [2:0] exp_d;
        rem = s; row = 0; plane = 0; col = 0; phase = 0; kind = -1;
        for (int r = 0; r < ROWS; r++) begin
            for (int p = 0; p < DEPTH; p++) begin
                if (kind < 0) begin
                    len = 2 * COLS + 1 + (BASE << p);
                    if (rem < len) begin
                        row = r; plane = p;
                        if (rem < 2 * COLS) begin
                            kind = 0; col = rem / 2; phase = rem % 2;
                        end else if (rem == 2 * COLS) begin
                            kind = 1;
                        end else begin
                            kind = 2;
                        end
                    end else begin
                        rem -= len;
                    end
                end
            end
        end
        case (kind)
            0: begin
                check("shift_sclk", sclk_out, phase);
                check("shift_latch", latch_out, 0);
                check("shift_blank", blank_out, 1);
                px = pix_ref(row, col);
                exp_d = {px[2*DEPTH+plane], px[DEPTH+plane], px[plane]};
                check("shift_data", {red_out, green_out, blue_out}, exp_d);
            end
            1: begin
                exp_row = row;
                check("latch_sclk", sclk_out, 0);
                check("latch_pulse", latch_out, 1);
                check("latch_blank", blank_out, 1);
            end
            default: begin
                check("disp_sclk", sclk_out, 0);
                check("disp_latch", latch_out, 0);
                check("disp_blank", blank_out, 0);
            end
        endcase
        check("row_out", row_out, exp_row);
    endtask

    always @(negedge clk) begin
        if (!reset_n) begin
            mode = 2; pos = 0; exp_row = 0; en_prev = 1'b0; sclk_prev = 1'b0;
            rises = 0; latches = 0;
        end else begin
            if (mode == 1) begin
                pos++;
                if (sclk_out && !sclk_prev) rises++;
                if (latch_out) latches++;
                check_frame_pos(pos - 1);
                if (pos == FRAME - 1) cont = en;
                if (pos == FRAME) begin
                    check("sclk_per_frame", rises, COLS * DEPTH * ROWS);
                    check("latch_per_frame", latches, DEPTH * ROWS);
                    rises = 0; latches = 0;
                    exp_fs = cont;
                    if (cont) pos = 0;
                    else mode = 2;
                end else begin
                    exp_fs = 1'b0;
                end
            end else begin
                check("idle_blank", blank_out, 1);
                check("idle_sclk", sclk_out, 0);
                check("idle_latch", latch_out, 0);
                check("idle_data", {red_out, green_out, blue_out}, 0);
                check("idle_row", row_out, exp_row);
                exp_fs = en_prev;
                if (en_prev) begin
                    mode = 1; pos = 0; rises = 0; latches = 0;
                end
            end
            check("frame_start", frame_start, exp_fs);
            en_prev   = en;
            sclk_prev = sclk_out;
        end
    end

    task automatic wait_frames(input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < n * FRAME + 10 && seen < n; i++) begin
            @(negedge clk);
            if (frame_start) seen++;
        end
        check("frames_seen", seen, n);
    endtask

    task automatic wait_idle();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 3 * FRAME && !ok; i++) begin
            @(posedge clk);
            #1;
            if (mode == 2 && !en) ok = 1'b1;
        end
        check("reach_idle", ok, 1);
    endtask

    task automatic randomize_img();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                img[r][c] = (3*DEPTH)'($urandom);
    endtask

    logic sweep_done = 1'b0;

    initial begin
        int n;
        logic hit;
        @(posedge sw_reset_n);
        hit = 1'b0;
        for (int i = 0; i < 20000 && !hit; i++) begin
            @(negedge clk);
            if (sw_fs) hit = 1'b1;
        end
        check("sweep_first_fs", hit, 1);
        n = 0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            n++;
            if (sw_fs) break;
        end
        check("sweep_period", n, SW_FRAME);
        check("sweep_row_wrap", sw_row_out, 15);
        sweep_done = 1'b1;
    end

    initial begin
        int n;
        logic hit;
        reset_n = 1'b0; sw_reset_n = 1'b0; en = 1'b0; pix_mode = 1'b0;
        randomize_img();
        repeat (3) @(posedge clk);
        #2;
        check("rst_blank", blank_out, 1);
        check("rst_sclk", sclk_out, 0);
        check("rst_latch", latch_out, 0);
        check("rst_data", {red_out, green_out, blue_out}, 0);
        check("rst_row", row_out, 0);
        check("rst_fs", frame_start, 0);
        reset_n = 1'b1; sw_reset_n = 1'b1;
        repeat (5) @(posedge clk);
        #2;

        // Fixed pattern r=col, g=~col, b=row over consecutive frames.
        en = 1'b1;
        wait_frames(3);
        @(posedge clk); #2;
        en = 1'b0;
        wait_idle();

        // Random images with en toggling randomly, including mid-frame.
        for (int it = 0; it < 4; it++) begin
            @(posedge clk); #2;
            pix_mode = 1'b1;
            randomize_img();
            repeat ($urandom_range(40, 160)) begin
                @(posedge clk); #2;
                en = ($urandom % 4) != 0;
            end
            en = 1'b0;
            wait_idle();
        end

        // Stop request dropped mid-frame: frame must still complete.
        @(posedge clk); #2;
        en = 1'b1;
        wait_frames(1);
        repeat ($urandom_range(5, 40)) @(posedge clk);
        #2;
        en = 1'b0;
        wait_idle();
        repeat (10) @(posedge clk);

        // Reset while shifting column 2.
        #2;
        en = 1'b1;
        wait_frames(1);
        hit = 1'b0;
        for (int i = 0; i < 4 * COLS && !hit; i++) begin
            @(posedge clk); #2;
            if (pix_col == CW'(2)) hit = 1'b1;
        end
        check("reach_col2", hit, 1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_blank", blank_out, 1);
        check("mid_rst_sclk", sclk_out, 0);
        check("mid_rst_latch", latch_out, 0);
        check("mid_rst_data", {red_out, green_out, blue_out}, 0);
        check("mid_rst_row", row_out, 0);
        check("mid_rst_fs", frame_start, 0);
        check("mid_rst_col", pix_col, 0);
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n++;
            if (frame_start) break;
        end
        check("restart_latency", n, 2);
        check("restart_row", row_out, 0);
        wait_frames(1);
        @(posedge clk); #2;
        en = 1'b0;
        wait_idle();

        for (int i = 0; i < 30000 && !sweep_done; i++) @(posedge clk);
        check("sweep_finished", sweep_done, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
